axi4lite_mem_master: RTL and testbench

AXI4LITE_MEM_MASTER -- requirements
Module: axi4lite_mem_master
Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 mem_read  in  1  load request from MEM stage.
REQ-005 mem_write  in  1  store request from MEM stage.
REQ-006 addr  in  ADDR_W  byte address (ALU result).
REQ-007 wdata  in  32  store data, byte/half in LSBs.
REQ-008 wstrb  in  4  byte enables from store_type/offset decode.
REQ-009 stall  out  1  freezes pipeline while transaction outstanding.
REQ-010 rdata  out  32  raw aligned read word, valid when done=1.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  completion error flag, qualified by done.
REQ-013 m_awaddr  out  ADDR_W  write address.
REQ-014 m_awvalid  out  1  write address valid.
REQ-015 m_awready  in  1  write address ready.
REQ-016 m_wdata  out  32  write data.
REQ-017 m_wstrb  out  4  write strobes.
REQ-018 m_wvalid  out  1  write data valid.
REQ-019 m_wready  in  1  write data ready.
REQ-020 m_bresp  in  2  write response.
REQ-021 m_bvalid  in  1  write response valid.
REQ-022 m_bready  out  1  write response ready.
REQ-023 m_araddr  out  ADDR_W  read address.
REQ-024 m_arvalid  out  1  read address valid.
REQ-025 m_arready  in  1  read address ready.
REQ-026 m_rdata  in  32  read data.
REQ-027 m_rresp  in  2  read response.
REQ-028 m_rvalid  in  1  read data valid.
REQ-029 m_rready  out  1  read data ready.
Function
REQ-030 FSM states SHALL be IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE; one transaction outstanding max.
REQ-031 In IDLE, mem_read|mem_write SHALL drive stall=1 combinationally and capture addr, wdata, wstrb, op into registers; upstream changes afterwards ignored.
REQ-032 IDLE->WR_AW_W on mem_write only, ->RD_AR on mem_read only; both high -> DONE with err=1, no bus activity.
REQ-033 m_awaddr/m_araddr SHALL be {addr[ADDR_W-1:2],2'b00}; m_wdata = wdata shifted left 8*addr[1:0]; m_wstrb = captured wstrb.
REQ-034 WR_AW_W: awvalid and wvalid raised together, each dropped independently after its handshake; ->WR_B once both done (same or different cycles).
REQ-035 WR_B: bready=1; on bvalid ->DONE, err = bresp!=OKAY.
REQ-036 RD_AR: arvalid=1 until arready ->RD_R; RD_R: rready=1, on rvalid capture m_rdata (0 if rresp!=OKAY), err = rresp!=OKAY, ->DONE.
REQ-037 Valids SHALL stay high until handshake, never depend combinationally on ready.
REQ-038 DONE: stall=0, done=1, rdata/err held valid; ->IDLE next cycle unconditionally.
REQ-039 stall SHALL be 1 in every state except DONE and idle-without-request; zero-wait latency 4 cycles, stall high exactly 3.
Reset
REQ-040 rst low SHALL immediately force IDLE, all valid/ready low, stall=0, done=0, err=0, rdata=0, mid-transaction included.
REQ-041 Outputs SHALL leave reset values only on first rising edge after rst deasserts.
Structure
REQ-042 State encodings and AXI resp codes (OKAY=00, SLVERR=10, DECERR=11) SHALL live in defines.vh; load extension stays in mem_stage.
REQ-043 Single flat module, no sub-module.
Verification
REQ-044 SW addr 0x104, wdata 0xDEADBEEF, wstrb 1111, zero-wait slave -> awaddr 0x104, wdata 0xDEADBEEF, stall 3 cycles, done, err=0.
REQ-045 SB addr 0x103, wdata 0xAB, wstrb 1000 -> awaddr 0x100, m_wdata 0xAB000000, m_wstrb 1000.
REQ-046 LW addr 0x200, slave rdata 0x12345678 after 5 rvalid waits -> stall 8 cycles, rdata 0x12345678 on done.
REQ-047 awready 3 cycles after wready -> wvalid drops after its handshake, awvalid held, single B handshake, done once.
REQ-048 Read rresp=SLVERR -> done, err=1, rdata 0; both mem_read and mem_write -> done, err=1, no valids.
REQ-049 rst low during WR_B -> all valids/readies low same cycle, IDLE after release, next request completes normally.

---
 rtl/axi4lite_mem_master_pkg.sv | 21 ++
 rtl/axi4lite_mem_master.sv | 148 ++++++++++++++
 tb/tb_axi4lite_mem_master.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_mem_master_pkg.sv
// Shared types for the MEM-stage AXI4-Lite master: FSM state encoding and AXI response codes.
package axi4lite_mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_mem_master.sv
// Turns a pipeline MEM-stage load/store into a single outstanding AXI4-Lite transaction,
// stalling the pipeline until the response is back.
module axi4lite_mem_master
  import axi4lite_mem_master_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_t            state;
  logic              active;
  logic              req;
  logic              req_accept;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // active stays low until the first clock edge after reset release so that
  // no output (stall included) moves before that edge.
  assign req        = mem_read | mem_write;
  assign req_accept = active && (state == IDLE) && req;
  assign stall      = active && (((state == IDLE) && req) ||
                                 ((state != IDLE) && (state != DONE)));

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;

  // Request capture: later upstream changes are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      addr_q  <= word_align(addr);
      wdata_q <= lane_shift(wdata, addr[1:0]);
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active    <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      active <= 1'b1;
      case (state)
        IDLE: begin
          if (req_accept) begin
            if (mem_read && mem_write) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (mem_write) begin
              state     <= WR_AW_W;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end else begin
              state     <= RD_AR;
              m_arvalid <= 1'b1;
            end
          end
        end
        WR_AW_W: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            state    <= WR_B;
            m_bready <= 1'b1;
          end
        end
        WR_B: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            state    <= DONE;
            done     <= 1'b1;
            err      <= resp_is_err(m_bresp);
          end
        end
        RD_AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            rdata    <= resp_is_err(m_rresp) ? 32'h0 : m_rdata;
            err      <= resp_is_err(m_rresp);
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_master.sv
// Randomised bench for axi4lite_mem_master: a configurable-latency AXI4-Lite slave plus a
// transaction-level reference model of expected addresses, data, latency and responses.
module tb_axi4lite_mem_master;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_read = 1'b0, mem_write = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              stall, done, err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic              m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]        m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0]       m_rdata = '0;

  int checks = 0;
  int errors = 0;

  axi4lite_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .stall(stall), .rdata(rdata), .done(done), .err(err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // Slave: readiness and responses decided on the falling edge, handshakes land on the next rising edge.
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  bit          aw_ok, w_ok, ar_ok, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, viol = 0;
  logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [31:0] slave_mem [1024];
  logic [31:0] ref_mem [1024];

  always @(negedge clk) begin
    if (!rst) begin
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      aw_ok = 0; w_ok = 0; ar_ok = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (aw_fire) aw_ok = 1;
      if (w_fire) w_ok = 1;
      if (b_fire) begin m_bvalid = 0; aw_ok = 0; w_ok = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; end
      if (ar_fire) ar_ok = 1;
      if (r_fire) begin m_rvalid = 0; ar_ok = 0; ar_cnt = 0; r_cnt = 0; end
      if ((aw_ok && m_awvalid) || (w_ok && m_wvalid) || (ar_ok && m_arvalid)) viol++;
      m_awready = m_awvalid && !aw_ok && (aw_cnt >= aw_wait);
      if (m_awvalid && !aw_ok && !m_awready) aw_cnt++;
      m_wready = m_wvalid && !w_ok && (w_cnt >= w_wait);
      if (m_wvalid && !w_ok && !m_wready) w_cnt++;
      m_arready = m_arvalid && !ar_ok && (ar_cnt >= ar_wait);
      if (m_arvalid && !ar_ok && !m_arready) ar_cnt++;
      if (aw_ok && w_ok && !m_bvalid) begin
        if (b_cnt >= b_wait) begin
          m_bvalid = 1; m_bresp = b_resp_cfg;
          if (b_resp_cfg == 2'b00)
            for (int b = 0; b < 4; b++)
              if (cap_wstrb[b]) slave_mem[cap_awaddr[11:2]][8*b +: 8] = cap_wdata[8*b +: 8];
        end else b_cnt++;
      end
      if (ar_ok && !m_rvalid) begin
        if (r_cnt >= r_wait) begin
          m_rvalid = 1; m_rresp = r_resp_cfg; m_rdata = slave_mem[cap_araddr[11:2]];
        end else r_cnt++;
      end
      aw_fire = m_awvalid && m_awready;
      if (aw_fire) begin cap_awaddr = m_awaddr; aw_hs++; end
      w_fire = m_wvalid && m_wready;
      if (w_fire) begin cap_wdata = m_wdata; cap_wstrb = m_wstrb; w_hs++; end
      b_fire = m_bvalid && m_bready;
      if (b_fire) b_hs++;
      ar_fire = m_arvalid && m_arready;
      if (ar_fire) begin cap_araddr = m_araddr; ar_hs++; end
      r_fire = m_rvalid && m_rready;
      if (r_fire) r_hs++;
    end
  end

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] bresp, input logic [1:0] rresp);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    b_resp_cfg = bresp; r_resp_cfg = rresp;
  endtask

  // Reference memory follows the architectural effect of an accepted store.
  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] lanes;
    lanes = d << (8 * int'(a[1:0]));
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[11:2]][8*b +: 8] = lanes[8*b +: 8];
  endtask

  // Drives one MEM-stage request, holding op while stalled and scrambling the operands.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output int stall_cycles, output int done_cnt,
                         output logic [31:0] rd_q, output logic err_q, output bit timed_out);
    bit seen;
    seen = 0; stall_cycles = 0; done_cnt = 0; rd_q = '0; err_q = 0; timed_out = 1;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (stall) stall_cycles++;
      if (done) begin
        done_cnt++;
        if (!seen) begin rd_q = rdata; err_q = err; end
      end
      if (seen) begin timed_out = 0; break; end
      if (done) seen = 1;
      @(negedge clk);
      if (seen) begin mem_read = 0; mem_write = 0; end
      else begin addr = $urandom; wdata = $urandom; wstrb = 4'($urandom); end
    end
    mem_read = 0; mem_write = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    mem_read = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL release_stall got %b want 0", stall); end
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL release_arvalid got %b want 0", m_arvalid); end
  endtask

  task automatic test_sw();
    int st, dc, aw0, b0; logic [31:0] rq; logic eq; bit to;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    aw0 = aw_hs; b0 = b_hs;
    run_txn(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 4'b1111, st, dc, rq, eq, to);
    ref_write(32'h104, 32'hDEADBEEF, 4'b1111);
    checks++; if (to) begin errors++; $display("FAIL sw_timeout no done within budget"); end
    checks++; if (st != 3) begin errors++; $display("FAIL sw_stall got %0d want 3", st); end
    checks++; if (dc != 1) begin errors++; $display("FAIL sw_done got %0d want 1", dc); end
    checks++; if (eq !== 1'b0) begin errors++; $display("FAIL sw_err got %b want 0", eq); end
    checks++; if (cap_awaddr !== 32'h104) begin errors++; $display("FAIL sw_awaddr got %h want 00000104", cap_awaddr); end
    checks++; if (cap_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", cap_wdata); end
    checks++;
    if (aw_hs - aw0 != 1 || b_hs - b0 != 1) begin
      errors++; $display("FAIL sw_handshakes got aw=%0d b=%0d want 1 1", aw_hs - aw0, b_hs - b0);
    end
  endtask

  task automatic test_sb();
    int st, dc; logic [31:0] rq; logic eq; bit to;
    run_txn(1'b0, 1'b1, 32'h103, 32'h000000AB, 4'b1000, st, dc, rq, eq, to);
    ref_write(32'h103, 32'h000000AB, 4'b1000);
    checks++; if (to || dc != 1) begin errors++; $display("FAIL sb_done got %0d want 1", dc); end
    checks++; if (cap_awaddr !== 32'h100) begin errors++; $display("FAIL sb_awaddr got %h want 00000100", cap_awaddr); end
    checks++; if (cap_wdata !== 32'hAB000000) begin errors++; $display("FAIL sb_wdata got %h want ab000000", cap_wdata); end
    checks++; if (cap_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b want 1000", cap_wstrb); end
  endtask

  task automatic test_lw_wait();
    int st, dc; logic [31:0] rq; logic eq; bit to;
    slave_mem[32'h200 >> 2] = 32'h12345678;
    ref_mem[32'h200 >> 2] = 32'h12345678;
    set_slave(0, 0, 0, 0, 5, 2'b00, 2'b00);
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, st, dc, rq, eq, to);
    checks++; if (to || dc != 1) begin errors++; $display("FAIL lw_done got %0d want 1", dc); end
    checks++; if (st != 8) begin errors++; $display("FAIL lw_stall got %0d want 8", st); end
    checks++; if (rq !== 32'h12345678) begin errors++; $display("FAIL lw_rdata got %h want 12345678", rq); end
    checks++; if (cap_araddr !== 32'h200) begin errors++; $display("FAIL lw_araddr got %h want 00000200", cap_araddr); end
  endtask

  task automatic test_aw_late();
    int st, dc, aw0, w0, b0, v0; logic [31:0] rq; logic eq; bit to;
    set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; v0 = viol;
    run_txn(1'b0, 1'b1, 32'h2A6, 32'h0000BEEF, 4'b1100, st, dc, rq, eq, to);
    ref_write(32'h2A6, 32'h0000BEEF, 4'b1100);
    checks++; if (to || dc != 1) begin errors++; $display("FAIL awlate_done got %0d want 1", dc); end
    checks++; if (st != 6) begin errors++; $display("FAIL awlate_stall got %0d want 6", st); end
    checks++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      errors++; $display("FAIL awlate_handshakes got aw=%0d w=%0d b=%0d want 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL awlate_valid_after_hs got %0d want %0d", viol, v0); end
    checks++; if (cap_wdata !== 32'hBEEF0000) begin errors++; $display("FAIL awlate_wdata got %h want beef0000", cap_wdata); end
  endtask

  task automatic test_errors();
    int st, dc, hs0; logic [31:0] rq; logic eq; bit to;
    set_slave(0, 0, 0, 0, 1, 2'b00, 2'b10);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, st, dc, rq, eq, to);
    checks++; if (to || dc != 1) begin errors++; $display("FAIL rd_slverr_done got %0d want 1", dc); end
    checks++; if (eq !== 1'b1) begin errors++; $display("FAIL rd_slverr_err got %b want 1", eq); end
    checks++; if (rq !== 32'h0) begin errors++; $display("FAIL rd_slverr_rdata got %h want 0", rq); end
    set_slave(0, 0, 0, 0, 0, 2'b11, 2'b00);
    run_txn(1'b0, 1'b1, 32'h34, 32'h55AA55AA, 4'b1111, st, dc, rq, eq, to);
    checks++; if (to || eq !== 1'b1) begin errors++; $display("FAIL wr_decerr_err got %b want 1", eq); end
    hs0 = aw_hs + w_hs + ar_hs;
    run_txn(1'b1, 1'b1, 32'h40, 32'h1, 4'b1111, st, dc, rq, eq, to);
    checks++; if (to || dc != 1) begin errors++; $display("FAIL both_done got %0d want 1", dc); end
    checks++; if (eq !== 1'b1) begin errors++; $display("FAIL both_err got %b want 1", eq); end
    checks++; if (st != 1) begin errors++; $display("FAIL both_stall got %0d want 1", st); end
    checks++; if (aw_hs + w_hs + ar_hs != hs0) begin errors++; $display("FAIL both_bus got %0d want %0d", aw_hs + w_hs + ar_hs, hs0); end
  endtask

  task automatic test_reset_mid();
    int st, dc; logic [31:0] rq; logic eq; bit to, reached;
    set_slave(0, 0, 20, 0, 0, 2'b00, 2'b00);
    reached = 0;
    @(negedge clk);
    mem_write = 1; addr = 32'h60; wdata = 32'hCAFEF00D; wstrb = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m_bready) begin reached = 1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach_wrb got 0 want 1"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      errors++; $display("FAIL rstmid_handshake got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if ({stall, done, err} !== 3'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs got stall=%b done=%b err=%b rdata=%h want 0", stall, done, err, rdata);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_release_stall got %b want 0", stall); end
    @(negedge clk);
    mem_write = 0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    run_txn(1'b0, 1'b1, 32'h64, 32'h0BADC0DE, 4'b1111, st, dc, rq, eq, to);
    ref_write(32'h64, 32'h0BADC0DE, 4'b1111);
    checks++;
    if (to || dc != 1 || st != 3 || eq !== 1'b0 || cap_awaddr !== 32'h64) begin
      errors++; $display("FAIL rstmid_next got done=%0d stall=%0d err=%b awaddr=%h want 1 3 0 00000064", dc, st, eq, cap_awaddr);
    end
  endtask

  task automatic test_random();
    int st, dc, op, aw, w, b, ar, r, exp_st, hs0;
    logic [31:0] rq, a, d, exp_rd; logic eq, exp_err; logic [3:0] s; logic [1:0] resp; bit to;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      a = {20'h0, 12'($urandom)}; d = $urandom; s = 4'($urandom);
      aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
      ar = $urandom_range(0, 3); r = $urandom_range(0, 3);
      resp = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11) : 2'b00;
      set_slave(aw, w, b, ar, r, resp, resp);
      hs0 = aw_hs + w_hs + ar_hs;
      if (op == 0) begin
        run_txn(1'b1, 1'b1, a, d, s, st, dc, rq, eq, to);
        checks++;
        if (to || dc != 1 || st != 1 || eq !== 1'b1 || aw_hs + w_hs + ar_hs != hs0) begin
          errors++; $display("FAIL rand_both[%0d] got done=%0d stall=%0d err=%b bus=%0d want 1 1 1 0", n, dc, st, eq, aw_hs + w_hs + ar_hs - hs0);
        end
      end else if (op <= 4) begin
        exp_rd  = (resp == 2'b00) ? ref_mem[a[11:2]] : 32'h0;
        exp_err = (resp != 2'b00);
        exp_st  = 1 + (ar + 1) + (r + 1);
        run_txn(1'b1, 1'b0, a, d, s, st, dc, rq, eq, to);
        checks++;
        if (to || dc != 1 || st != exp_st || eq !== exp_err) begin
          errors++; $display("FAIL rand_rd_ctl[%0d] got done=%0d stall=%0d err=%b want 1 %0d %b", n, dc, st, eq, exp_st, exp_err);
        end
        checks++;
        if (rq !== exp_rd || cap_araddr !== (a & ~32'h3)) begin
          errors++; $display("FAIL rand_rd_data[%0d] got rdata=%h araddr=%h want %h %h", n, rq, cap_araddr, exp_rd, a & ~32'h3);
        end
      end else begin
        exp_err = (resp != 2'b00);
        exp_st  = 1 + (((aw > w) ? aw : w) + 1) + (b + 1);
        run_txn(1'b0, 1'b1, a, d, s, st, dc, rq, eq, to);
        if (resp == 2'b00) ref_write(a, d, s);
        checks++;
        if (to || dc != 1 || st != exp_st || eq !== exp_err) begin
          errors++; $display("FAIL rand_wr_ctl[%0d] got done=%0d stall=%0d err=%b want 1 %0d %b", n, dc, st, eq, exp_st, exp_err);
        end
        checks++;
        if (cap_awaddr !== (a & ~32'h3) || cap_wdata !== (d << (8 * int'(a[1:0]))) || cap_wstrb !== s) begin
          errors++; $display("FAIL rand_wr_data[%0d] got awaddr=%h wdata=%h wstrb=%b want %h %h %b", n,
                             cap_awaddr, cap_wdata, cap_wstrb, a & ~32'h3, d << (8 * int'(a[1:0])), s);
        end
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL valid_after_handshake got %0d want 0", viol); end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom; slave_mem[i] = v; ref_mem[i] = v;
    end
    test_reset();
    test_sw();
    test_sb();
    test_lw_wait();
    test_aw_late();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
